seq_detect_prog: RTL and testbench

SEQ_DETECT_PROG -- requirements
Module: seq_detect_prog

---
 rtl/seq_detect_pkg.sv | 12 +
 rtl/seq_detect_cmp.sv | 22 ++
 rtl/seq_detect_prog.sv | 93 +++++++++
 tb/tb_seq_detect_prog.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared types and default sizing for the programmable serial sequence detector.
package seq_detect_pkg;

  localparam int MAX_LEN_DEF = 8;
  localparam int CNT_W_DEF   = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/seq_detect_cmp.sv
// Masked compare: the newest len bits of hist against pat; bits at and above len are ignored.
module seq_detect_cmp
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic [MAX_LEN-1:0] hist,
  input  logic [MAX_LEN-1:0] pat,
  input  logic [LW-1:0]      len,
  output logic               eq
);

  logic [MAX_LEN-1:0] mask;

  for (genvar i = 0; i < MAX_LEN; i++) begin : g_mask
    assign mask[i] = (32'(i) < 32'(len));
  end

  assign eq = (((hist ^ pat) & mask) == '0);

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable serial sequence detector with overlap/non-overlap modes.
// Define SEQ_DETECT_CNT_EN to add the saturating match_cnt output.
module seq_detect_prog
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         x,
  input  logic                         x_valid,
  input  logic                         load,
  input  logic [MAX_LEN-1:0]           pat_in,
  input  logic [$clog2(MAX_LEN+1)-1:0] len_in,
  input  logic                         overlap,
  output logic                         y,
  output logic                         armed
`ifdef SEQ_DETECT_CNT_EN
  ,output logic [CNT_W-1:0]            match_cnt
`endif
);

  localparam int LW = $clog2(MAX_LEN + 1);

  // Out-of-range parameters elaborate an empty, clearly named block.
  if (CNT_W < 1 || MAX_LEN < 2 || MAX_LEN > 32) begin : g_param_out_of_range
  end

  state_e             state, state_nxt;
  logic [MAX_LEN-1:0] hist, pat;
  logic [LW-1:0]      len, fill;
  logic [MAX_LEN-1:0] hist_nxt;
  logic               eq, fill_ok, len_ok, sample, match;

  assign hist_nxt = {hist[MAX_LEN-2:0], x};
  assign fill_ok  = ({1'b0, fill} + (LW+1)'(1)) >= {1'b0, len};
  assign len_ok   = (len_in != '0) && (len_in <= LW'(MAX_LEN));
  // load owns the cycle: a coincident x sample is dropped.
  assign sample   = (state == RUN) && x_valid && !load;
  assign match    = sample && eq && fill_ok;
  assign armed    = (state == RUN);

  seq_detect_cmp #(.MAX_LEN(MAX_LEN), .LW(LW)) u_cmp (
    .hist (hist_nxt),
    .pat  (pat),
    .len  (len),
    .eq   (eq)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (load) state_nxt = len_ok ? RUN : IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist <= '0;
      pat  <= '0;
      len  <= '0;
      fill <= '0;
      y    <= 1'b0;
    end else if (load) begin
      hist <= '0;
      pat  <= pat_in;
      len  <= len_in;
      fill <= '0;
      y    <= 1'b0;
    end else begin
      y <= match;
      if (sample) begin
        hist <= hist_nxt;
        // Non-overlap restarts the fill so the next hit needs len fresh bits.
        if (match && !overlap)         fill <= '0;
        else if (fill != LW'(MAX_LEN)) fill <= fill + LW'(1);
      end
    end
  end

`ifdef SEQ_DETECT_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         match_cnt <= '0;
    else if (load)                     match_cnt <= '0;
    else if (match && match_cnt != '1) match_cnt <= match_cnt + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// Scoreboard bench for seq_detect_prog: expected y per cycle is queued at drive time, popped after the edge.
module tb_seq_detect_prog;

  localparam int ML = 8;
  localparam int CW = 2;
  localparam int LW = $clog2(ML + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          x = 1'b0, x_valid = 1'b0, load = 1'b0, overlap = 1'b0;
  logic [ML-1:0] pat_in = '0;
  logic [LW-1:0] len_in = '0;
  logic          y, armed;
`ifdef SEQ_DETECT_CNT_EN
  logic [CW-1:0] match_cnt;
`endif

  int   n_chk = 0, n_err = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  seq_detect_prog #(.MAX_LEN(ML), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .x         (x),
    .x_valid   (x_valid),
    .load      (load),
    .pat_in    (pat_in),
    .len_in    (len_in),
    .overlap   (overlap),
    .y         (y),
    .armed     (armed)
`ifdef SEQ_DETECT_CNT_EN
    ,.match_cnt(match_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input int exp);
`ifdef SEQ_DETECT_CNT_EN
    chk(tag, 32'(match_cnt), exp);
`endif
  endtask

  // One clock: drive at negedge, queue the expected y, compare at the next negedge.
  task automatic cyc(input logic xv, input logic xb, input logic ld, input logic e, input string tag);
    logic e_pop;
    x_valid = xv; x = xb; load = ld;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    x_valid = 1'b0; load = 1'b0;
    e_pop = exp_q.pop_front();
    chk(tag, 32'(y), 32'(e_pop));
  endtask

  task automatic do_load(input logic [ML-1:0] p, input logic [LW-1:0] l, input logic ov);
    pat_in = p; len_in = l; overlap = ov;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, "load_y");
  endtask

  // bits/exp listed oldest-first in the MSB of an n-bit field.
  task automatic stream(input string tag, input logic [15:0] bits, input logic [15:0] exp,
                        input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, bits[n-1-i], 1'b0, exp[n-1-i], $sformatf("%s_b%0d", tag, i));
      if (gaps) cyc(1'b0, 1'b0, 1'b0, 1'b0, $sformatf("%s_gap%0d", tag, i));
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_y", 32'(y), 0);
    chk("rst_armed", 32'(armed), 0);
    chk_cnt("rst_cnt", 0);
    reset = 1'b0;
    @(negedge clk);

    // overlapping 000
    do_load(8'b000, 4'd3, 1'b1);
    chk("t1_armed", 32'(armed), 1);
    stream("t1", 16'b0000, 16'b0011, 4, 1'b0);
    chk_cnt("t1_cnt", 2);

    // non-overlapping 000
    do_load(8'b000, 4'd3, 1'b0);
    chk_cnt("t2_cnt_clr", 0);
    stream("t2", 16'b000000, 16'b001001, 6, 1'b0);
    chk_cnt("t2_cnt", 2);

    // 1011 with x_valid gaps, overlapping
    do_load(8'b1011, 4'd4, 1'b1);
    stream("t3", 16'b1011011, 16'b0001001, 7, 1'b1);

    // illegal lengths leave the block idle
    do_load(8'b000, 4'd0, 1'b1);
    chk("t4_armed0", 32'(armed), 0);
    stream("t4", 16'b000, 16'b000, 3, 1'b0);
    chk("t4_armed0_after", 32'(armed), 0);
    do_load(8'b000, 4'd9, 1'b1);
    chk("t4_armed9", 32'(armed), 0);

    // mid-stream reset aborts detection
    do_load(8'b000, 4'd3, 1'b1);
    stream("t5_pre", 16'b00, 16'b00, 2, 1'b0);
    reset = 1'b1;
    #1;
    chk("t5_rst_armed", 32'(armed), 0);
    chk("t5_rst_y", 32'(y), 0);
    @(negedge clk);
    reset = 1'b0;
    stream("t5_post", 16'b0, 16'b0, 1, 1'b0);
    chk("t5_armed", 32'(armed), 0);

    // len 1, counter saturation, load beats x_valid
    do_load(8'b0, 4'd1, 1'b1);
    stream("t6", 16'b00000, 16'b11111, 5, 1'b0);
    chk_cnt("t6_sat", 3);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, "t6_ld_vs_x");
    chk_cnt("t6_cnt_clr", 0);
    chk("t6_armed", 32'(armed), 1);
    stream("t6_after", 16'b0, 16'b1, 1, 1'b0);
    chk_cnt("t6_cnt1", 1);

    // full-width pattern
    do_load(8'hA5, 4'd8, 1'b1);
    stream("t7", 16'h00A5, 16'h0001, 8, 1'b0);
    stream("t7_miss", 16'b0, 16'b0, 1, 1'b0);

    // overlap switched off mid-stream: 11 pattern on a run of ones
    do_load(8'b11, 4'd2, 1'b1);
    stream("t8_ov", 16'b111, 16'b011, 3, 1'b0);
    overlap = 1'b0;
    stream("t8_nov", 16'b111, 16'b101, 3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
